nn_accel_subsystem: RTL and testbench
=====================================

// Module: nn_accel_subsystem
// PURPOSE
//  Neural-inference subsystem for the single-cycle ARM SoC: a 1 KiB mixed-width true dual-port RAM
//  (32-bit CPU port, 8-bit engine port) plus an int8 fully-connected-layer engine. The CPU stores
//  inputs/weights, pulses run_inference, and takes an interrupt on the rising edge of ready, then
//  reads the results back through the same RAM.
// PARAMETERS
//  N_IN     16     inputs per neuron (1..64)
//  N_OUT    4      neurons (1..16)
//  SHIFT    4      arithmetic right shift applied to accumulator before activation
//  IN_BASE  10'h100 byte address of input vector x[0..N_IN-1]
//  W_BASE   10'h200 byte address of weights, row-major: w[j][i] at W_BASE + j*N_IN + i
//  OUT_BASE 10'h300 byte address of outputs y[0..N_OUT-1]
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  reset          in   1   reset, asynchronous, active-high
//  run_inference  in   1   start request, level-sampled each rising edge
//  ready          out  1   1 = results valid; 0 = idle-after-reset or busy
//  cpu_addr       in   30  CPU word address (byte addr [31:2]); only [7:0] used, [29:8] ignored
//  cpu_wd         in   32  CPU write data
//  cpu_we         in   1   CPU word write enable
//  cpu_rd         out  32  CPU read data, combinational from cpu_addr[7:0]
// BEHAVIOUR
//  RAM: 256 x 32 bit = 1024 bytes, not reset, no initial contents required.
//  - Little-endian: byte b = word b[9:2], bits [8*b[1:0]+7 : 8*b[1:0]].
//  - Both read ports asynchronous (combinational); writes on rising clk edge.
//  - Same-cycle read of an address being written returns old data.
//  - Byte collision (engine write and cpu_we to same word): CPU word write wins for all 4 bytes.
//  Engine (internal 10-bit byte address, 8-bit wd/rd, 1-bit we onto RAM byte port):
//  - States: IDLE, CLEAR, FETCH_X, FETCH_W, WRITE.
//  - IDLE: run_inference=1 at edge -> CLEAR, ready<=0, j<=0. run_inference ignored in all other states.
//  - CLEAR (1 cycle): acc<=0, i<=0 -> FETCH_X.
//  - FETCH_X: addr=IN_BASE+i, latch x=rd -> FETCH_W.
//  - FETCH_W: addr=W_BASE+j*N_IN+i, acc<=acc+signed(x)*signed(rd); i==N_IN-1 ? WRITE : (i++, FETCH_X).
//  - WRITE (1 cycle): addr=OUT_BASE+j, we=1, wd=clamp(acc>>>SHIFT, 0, 127) (ReLU + saturate);
//    j==N_OUT-1 ? (IDLE, ready<=1) : (j++, CLEAR).
//  - acc: 32-bit signed; x, w are two's-complement int8; no overflow possible for legal params.
//  - Latency: ready rises N_OUT*(2*N_IN+2) edges after the edge that sampled run_inference
//    (136 cycles at defaults); ready then holds 1 until the next accepted start.
//  - Engine we asserted only in WRITE; address wraps modulo 1024.
//  Reset (any time, incl. mid-inference): state=IDLE, ready=0, engine we=0, address=0, wd=0,
//  acc/i/j=0; RAM contents preserved. ready=0 after reset so no spurious interrupt edge.
// TESTING
//  1 CPU writes 0x44332211 to word 0x40 -> engine byte reads 0x100=0x11, 0x103=0x44; cpu_rd=0x44332211.
//  2 x[i]=4; w row0=4, row1=-4 (0xFC), row2=127, row3 alternating 1,-1; pulse run_inference 1 cycle
//    -> ready rises exactly 136 cycles later; bytes 0x300..0x303 = 16,0,127,0; cpu_rd @word 0xC0 = 0x007F0010.
//  3 Hold run_inference high during busy -> no restart, ready still at 136; held high after done -> restarts.
//  4 Assert reset at cycle 50 of inference -> ready=0, engine we=0 immediately; RAM inputs intact;
//    a new start then completes normally with the results of test 2.
//  5 cpu_we to word 0xC0 in the same cycle as engine WRITE of byte 0x300 -> word holds CPU data.
//  6 cpu_addr=30'h100 (upper bits set) aliases word 0x00 -> same data as cpu_addr=0.

Source files
------------

// File: rtl/nn_accel_subsystem.sv
`default_nettype none
// ============================================================================
// Module      : nn_accel_subsystem
// Description : Neural-inference subsystem. It holds a 1 KiB mixed-width RAM
//               with a 32-bit CPU word port and an 8-bit engine byte port,
//               and an int8 fully-connected-layer engine that computes
//               y[j] = clamp((sum_i x[i]*w[j][i]) >>> SHIFT, 0, 127).
// Revision    : 1.0 - initial release
// ============================================================================
module nn_accel_subsystem #(
    parameter int         N_IN     = 16,
    parameter int         N_OUT    = 4,
    parameter int         SHIFT    = 4,
    parameter logic [9:0] IN_BASE  = 10'h100,
    parameter logic [9:0] W_BASE   = 10'h200,
    parameter logic [9:0] OUT_BASE = 10'h300
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_run_inference,
    output logic        o_ready,
    input  logic [29:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wd,
    input  logic        i_cpu_we,
    output logic [31:0] o_cpu_rd
);

    localparam logic [9:0] c_N_IN_B = 10'(N_IN);
    localparam logic [6:0] c_I_LAST = 7'(N_IN - 1);
    localparam logic [4:0] c_J_LAST = 5'(N_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_FETCH_X = 3'd2,
        S_FETCH_W = 3'd3,
        S_WRITE   = 3'd4
    } state_t;

    state_t             r_state;
    logic [6:0]         r_i;
    logic [4:0]         r_j;
    logic signed [31:0] r_acc;
    logic [7:0]         r_x;
    logic               r_ready;

    // 256 x 32 storage; byte b lives in word b[9:2], lane b[1:0] (little-endian)
    logic [31:0]        r_mem [0:255];

    logic [9:0]         w_eng_addr;
    logic               w_eng_we;
    logic [7:0]         w_eng_wd;
    logic [31:0]        w_eng_word;
    logic [7:0]         w_eng_rd;
    logic [9:0]         w_row_base;
    logic signed [15:0] w_prod;
    logic signed [31:0] w_shifted;
    logic [7:0]         w_sat;
    logic               w_collide;
    logic               w_unused_addr;

    // Only the low 8 word-address bits select the RAM; the rest alias
    assign w_unused_addr = ^i_cpu_addr[29:8];

    assign o_ready    = r_ready;
    assign o_cpu_rd   = r_mem[i_cpu_addr[7:0]];
    assign w_eng_word = r_mem[w_eng_addr[9:2]];
    assign w_eng_rd   = w_eng_word[{w_eng_addr[1:0], 3'b000} +: 8];
    assign w_prod     = $signed(r_x) * $signed(w_eng_rd);
    assign w_shifted  = r_acc >>> SHIFT;
    assign w_collide  = i_cpu_we && (i_cpu_addr[7:0] == w_eng_addr[9:2]);

    // ReLU followed by saturation to the positive int8 range
    always_comb begin
        if (w_shifted[31]) begin
            w_sat = 8'd0;
        end else if (w_shifted > 32'sd127) begin
            w_sat = 8'd127;
        end else begin
            w_sat = w_shifted[7:0];
        end
    end

    // Engine byte-port address, write strobe and data decoded from state
    always_comb begin
        w_row_base = {5'd0, r_j} * c_N_IN_B;
        w_eng_addr = 10'd0;
        w_eng_we   = 1'b0;
        w_eng_wd   = 8'd0;
        case (r_state)
            S_FETCH_X: w_eng_addr = IN_BASE + {3'd0, r_i};
            S_FETCH_W: w_eng_addr = W_BASE + w_row_base + {3'd0, r_i};
            S_WRITE: begin
                w_eng_addr = OUT_BASE + {5'd0, r_j};
                w_eng_we   = 1'b1;
                w_eng_wd   = w_sat;
            end
            default: ;
        endcase
    end

    // RAM writes; a CPU word write to the same word overrides the engine byte
    always_ff @(posedge clk) begin
        if (w_eng_we && !w_collide) begin
            r_mem[w_eng_addr[9:2]][{w_eng_addr[1:0], 3'b000} +: 8] <= w_eng_wd;
        end
        if (i_cpu_we) begin
            r_mem[i_cpu_addr[7:0]] <= i_cpu_wd;
        end
    end

    // Engine sequencer: per neuron CLEAR, N_IN x (FETCH_X, FETCH_W), WRITE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_acc   <= 32'sd0;
            r_i     <= 7'd0;
            r_j     <= 5'd0;
            r_x     <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_run_inference) begin
                        r_state <= S_CLEAR;
                        r_ready <= 1'b0;
                        r_j     <= 5'd0;
                    end
                end
                S_CLEAR: begin
                    r_acc   <= 32'sd0;
                    r_i     <= 7'd0;
                    r_state <= S_FETCH_X;
                end
                S_FETCH_X: begin
                    r_x     <= w_eng_rd;
                    r_state <= S_FETCH_W;
                end
                S_FETCH_W: begin
                    r_acc <= r_acc + 32'(w_prod);
                    if (r_i == c_I_LAST) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_i     <= r_i + 7'd1;
                        r_state <= S_FETCH_X;
                    end
                end
                S_WRITE: begin
                    if (r_j == c_J_LAST) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end else begin
                        r_j     <= r_j + 5'd1;
                        r_state <= S_CLEAR;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nn_accel_subsystem.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_accel_subsystem
// Description : Scoreboard bench for nn_accel_subsystem. Expected CPU read
//               data and ready-rise cycles are queued by the stimulus; two
//               monitors pop and compare when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_accel_subsystem;

    localparam int N_IN     = 16;
    localparam int N_OUT    = 4;
    localparam int SHIFT    = 4;
    localparam int IN_BASE  = 'h100;
    localparam int W_BASE   = 'h200;
    localparam int OUT_BASE = 'h300;
    localparam int LAT      = N_OUT * (2 * N_IN + 2);

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        run      = 1'b0;
    logic        cpu_we   = 1'b0;
    logic [29:0] cpu_addr = 30'd0;
    logic [31:0] cpu_wd   = 32'd0;
    logic        ready;
    logic [31:0] cpu_rd;

    nn_accel_subsystem dut (
        .clk             (clk),
        .reset           (reset),
        .i_run_inference (run),
        .o_ready         (ready),
        .i_cpu_addr      (cpu_addr),
        .i_cpu_wd        (cpu_wd),
        .i_cpu_we        (cpu_we),
        .o_cpu_rd        (cpu_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    int          ready_q[$];
    logic [7:0]  mem_m [0:1023];
    int          y_m [N_OUT];
    int          cyc        = 0;
    int          n_checks   = 0;
    int          n_pass     = 0;
    logic        prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] mw(input logic [7:0] a);
        return {mem_m[{a, 2'd3}], mem_m[{a, 2'd2}], mem_m[{a, 2'd1}], mem_m[{a, 2'd0}]};
    endfunction

    // Reference: dot products in plain integer arithmetic, then ReLU/saturate
    task automatic model_compute();
        int acc, xv, wv, s;
        for (int j = 0; j < N_OUT; j++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++) begin
                xv = $signed(mem_m[(IN_BASE + i) % 1024]);
                wv = $signed(mem_m[(W_BASE + j * N_IN + i) % 1024]);
                acc = acc + xv * wv;
            end
            s = acc >>> SHIFT;
            y_m[j] = (s < 0) ? 0 : ((s > 127) ? 127 : s);
        end
    endtask

    task automatic model_commit(input int first, input int last);
        for (int j = first; j <= last; j++) mem_m[(OUT_BASE + j) % 1024] = 8'(y_m[j]);
    endtask

    // Read-data monitor: one queued expectation per presented CPU address
    always @(negedge clk) begin : rd_monitor
        rd_exp_t e;
        if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            chk(e.name, cpu_rd, e.exp);
        end
    end

    // Ready monitor: each rising edge of ready must match a queued cycle
    always @(negedge clk) begin : ready_monitor
        int exp_c;
        if (ready && !prev_ready) begin
            if (ready_q.size() == 0) begin
                chk("spurious_ready", 32'd1, 32'd0);
            end else begin
                exp_c = ready_q.pop_front();
                chk("ready_rise_cycle", cyc, exp_c);
            end
        end
        prev_ready <= ready;
    end

    task automatic cpu_write(input logic [7:0] wa, input logic [31:0] d);
        @(negedge clk);
        cpu_addr = {22'd0, wa};
        cpu_wd   = d;
        cpu_we   = 1'b1;
        @(posedge clk);
        #1 cpu_we = 1'b0;
        for (int b = 0; b < 4; b++) mem_m[{wa, 2'(b)}] = d[8*b +: 8];
    endtask

    task automatic cpu_read(input logic [29:0] a, input logic [31:0] exp, input string name);
        rd_exp_t e;
        @(negedge clk);
        #1;
        cpu_addr = a;
        e.name = name;
        e.exp  = exp;
        rd_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        run = 1'b1;
        ready_q.push_back(cyc + 1 + LAT);
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        #1;
    endtask

    task automatic load_directed();
        for (int k = 0; k < 4; k++) cpu_write(8'h40 + 8'(k), 32'h04040404);
        for (int k = 0; k < 4; k++) cpu_write(8'h80 + 8'(k), 32'h04040404);
        for (int k = 0; k < 4; k++) cpu_write(8'h84 + 8'(k), 32'hFCFCFCFC);
        for (int k = 0; k < 4; k++) cpu_write(8'h88 + 8'(k), 32'h7F7F7F7F);
        for (int k = 0; k < 4; k++) cpu_write(8'h8C + 8'(k), 32'hFF01FF01);
    endtask

    task automatic load_random();
        for (int k = 0; k < 4; k++)  cpu_write(8'h40 + 8'(k), $urandom);
        for (int k = 0; k < 16; k++) cpu_write(8'h80 + 8'(k), $urandom);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int          c, t;
        logic [31:0] d;

        // Reset state
        repeat (3) @(posedge clk);
        #1 chk("reset_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Test 1: CPU word write / readback
        cpu_write(8'h40, 32'h44332211);
        cpu_read(30'h40, 32'h44332211, "t1_word40");

        // Test 6: upper address bits ignored
        d = $urandom;
        cpu_write(8'h00, d);
        cpu_read(30'h100, d, "t6_alias_100");
        cpu_read(30'h0, d, "t6_addr0");
        cpu_read(30'h3FFFFF05 & 30'h3FFFFFFF, mw(8'h05), "t6_alias_high");

        // Test 2: directed inference
        load_directed();
        start_pulse();
        wait_ready();
        model_compute();
        model_commit(0, N_OUT - 1);
        cpu_read(30'hC0, 32'h007F0010, "t2_out_const");
        cpu_read(30'hC0, mw(8'hC0), "t2_out_model");

        // Test 3: held start ignored while busy, re-accepted once done
        @(negedge clk);
        run = 1'b1;
        ready_q.push_back(cyc + 1 + LAT);
        t = 0;
        while (!ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("t3_ready_timeout", 32'd0, 32'd1);
        ready_q.push_back(cyc + 1 + LAT);
        @(negedge clk);
        #1 chk("t3_restart_drops_ready", {31'd0, ready}, 32'd0);
        repeat (3) @(negedge clk);
        run = 1'b0;
        wait_ready();
        cpu_read(30'hC0, mw(8'hC0), "t3_out");

        // Asynchronous reset while results are valid clears ready at once
        @(negedge clk);
        reset = 1'b1;
        #1 chk("reset_clears_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Test 4: reset mid-inference, RAM preserved, clean restart
        start_pulse();
        repeat (49) @(negedge clk);
        reset = 1'b1;
        #1 chk("t4_reset_ready", {31'd0, ready}, 32'd0);
        ready_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) cpu_read(30'h40 + 30'(k), mw(8'h40 + 8'(k)), "t4_inputs_kept");
        start_pulse();
        wait_ready();
        cpu_read(30'hC0, 32'h007F0010, "t4_out_const");

        // Test 5: CPU word write collides with engine WRITE of byte 0x300
        d = 32'hA5A5A5A5;
        @(negedge clk);
        run = 1'b1;
        c = cyc;
        ready_q.push_back(c + 1 + LAT);
        @(negedge clk);
        run = 1'b0;
        t = 0;
        while (cyc != c + 34 && t < 100) begin
            @(negedge clk);
            t++;
        end
        cpu_addr = 30'hC0;
        cpu_wd   = d;
        cpu_we   = 1'b1;
        @(posedge clk);
        #1 cpu_we = 1'b0;
        wait_ready();
        model_compute();
        model_commit(0, 0);
        for (int b = 0; b < 4; b++) mem_m[{8'hC0, 2'(b)}] = d[8*b +: 8];
        model_commit(1, N_OUT - 1);
        cpu_read(30'hC0, mw(8'hC0), "t5_collision");

        // Randomized inferences against the reference model
        for (int r = 0; r < 4; r++) begin
            load_random();
            start_pulse();
            wait_ready();
            model_compute();
            model_commit(0, N_OUT - 1);
            cpu_read(30'hC0, mw(8'hC0), "rand_out");
        end

        repeat (3) @(negedge clk);
        while (ready_q.size() > 0) begin
            void'(ready_q.pop_front());
            chk("ready_never_rose", 32'd0, 32'd1);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
